// File: rtl/alu_serial_pkg.sv
// Shared constants, state encoding and helpers for the bit-serial ALU sequencer.
package alu_serial_pkg;

    localparam logic [3:0] ALU_CTL_AND = 4'b0000;
    localparam logic [3:0] ALU_CTL_OR  = 4'b0001;
    localparam logic [3:0] ALU_CTL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTL_SUB = 4'b0110;
    localparam logic [3:0] ALU_CTL_SLT = 4'b0111;
    localparam logic [3:0] ALU_CTL_NOR = 4'b1100;

    localparam logic [1:0] SLICE_OP_AND  = 2'b00;
    localparam logic [1:0] SLICE_OP_OR   = 2'b01;
    localparam logic [1:0] SLICE_OP_ADD  = 2'b10;
    localparam logic [1:0] SLICE_OP_LESS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_SLT_FIX = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    function automatic logic is_arith(input logic [3:0] ctl);
        return (ctl == ALU_CTL_ADD) || (ctl == ALU_CTL_SUB) || (ctl == ALU_CTL_SLT);
    endfunction

endpackage

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer driving an external 1-bit ALU slice, LSB first.
// Optional macro ALU_FAST_LOGIC_EN: logic ops (ctl[1]==0) finish in one parallel cycle.
module alu_serial_ctrl
    import alu_serial_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_ainvert,
    output logic             slice_binvert,
    output logic [1:0]       slice_op,
    output logic             slice_less,
    output logic             slice_cin,
    input  logic             slice_result,
    input  logic             slice_cout
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_result_nxt;
    logic [WIDTH-1:0] w_fast_result;
    logic [WIDTH-1:0] w_a_inv;
    logic [WIDTH-1:0] w_b_inv;
    logic [3:0]       r_ctl;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_msb_sum;
    logic             r_overflow;
    logic             r_zero;
    logic             r_out_valid;
    logic             w_last_bit;
    logic             w_fast;
    logic             w_is_slt;

`ifdef ALU_FAST_LOGIC_EN
    assign w_fast = (r_ctl[1] == 1'b0);
`else
    assign w_fast = 1'b0;
`endif

    assign w_last_bit    = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_is_slt      = (r_ctl == ALU_CTL_SLT);
    assign w_a_inv       = r_a ^ {WIDTH{r_ctl[3]}};
    assign w_b_inv       = r_b ^ {WIDTH{r_ctl[2]}};
    assign w_fast_result = r_ctl[0] ? (w_a_inv | w_b_inv) : (w_a_inv & w_b_inv);

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_overflow;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, slice drive and next result image
    always_comb begin
        w_state_nxt   = r_state;
        w_result_nxt  = r_result;
        slice_a       = 1'b0;
        slice_b       = 1'b0;
        slice_ainvert = 1'b0;
        slice_binvert = 1'b0;
        slice_op      = SLICE_OP_AND;
        slice_less    = 1'b0;
        slice_cin     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_fast) begin
                    w_result_nxt = w_fast_result;
                    w_state_nxt  = ST_DONE;
                end else begin
                    slice_a       = r_a[r_cnt];
                    slice_b       = r_b[r_cnt];
                    slice_ainvert = r_ctl[3];
                    slice_binvert = r_ctl[2];
                    slice_op      = w_is_slt ? SLICE_OP_ADD : r_ctl[1:0];
                    slice_cin     = r_carry;
                    w_result_nxt[r_cnt] = slice_result;
                    if (w_last_bit) begin
                        w_state_nxt = w_is_slt ? ST_SLT_FIX : ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_SLT_FIX: begin
                // Re-run bit 0 with the sign of the true difference fed into Less
                slice_a       = r_a[0];
                slice_b       = r_b[0];
                slice_ainvert = r_ctl[3];
                slice_binvert = r_ctl[2];
                slice_op      = SLICE_OP_LESS;
                slice_less    = r_msb_sum ^ r_overflow;
                w_result_nxt  = {{(WIDTH-1){1'b0}}, slice_result};
                w_state_nxt   = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand latch, bit counter, carry chain and result/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= {WIDTH{1'b0}};
            r_b         <= {WIDTH{1'b0}};
            r_ctl       <= 4'b0000;
            r_cnt       <= {CNT_W{1'b0}};
            r_carry     <= 1'b0;
            r_msb_sum   <= 1'b0;
            r_result    <= {WIDTH{1'b0}};
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a        <= op_a;
                        r_b        <= op_b;
                        r_ctl      <= alu_ctl;
                        r_cnt      <= {CNT_W{1'b0}};
                        r_carry    <= alu_ctl[2];
                        r_msb_sum  <= 1'b0;
                        r_result   <= {WIDTH{1'b0}};
                        r_zero     <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_result <= w_result_nxt;
                    if (w_fast) begin
                        r_overflow  <= 1'b0;
                        r_zero      <= (w_result_nxt == {WIDTH{1'b0}});
                        r_out_valid <= 1'b1;
                    end else begin
                        r_carry <= slice_cout;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (w_last_bit) begin
                            r_msb_sum  <= slice_result;
                            r_overflow <= is_arith(r_ctl) ? (r_carry ^ slice_cout) : 1'b0;
                            if (!w_is_slt) begin
                                r_zero      <= (w_result_nxt == {WIDTH{1'b0}});
                                r_out_valid <= 1'b1;
                            end
                        end
                    end
                end
                ST_SLT_FIX: begin
                    r_result    <= w_result_nxt;
                    r_zero      <= (w_result_nxt == {WIDTH{1'b0}});
                    r_out_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl with a behavioural 1-bit ALU slice.
module tb_alu_serial_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   alu_ctl = 4'b0000;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         slice_a, slice_b, slice_ainvert, slice_binvert, slice_less, slice_cin;
    logic [1:0]   slice_op;
    logic         slice_result, slice_cout;

    int checks = 0;
    int errors = 0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .alu_ctl(alu_ctl),
        .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .overflow(overflow),
        .slice_a(slice_a), .slice_b(slice_b),
        .slice_ainvert(slice_ainvert), .slice_binvert(slice_binvert),
        .slice_op(slice_op), .slice_less(slice_less), .slice_cin(slice_cin),
        .slice_result(slice_result), .slice_cout(slice_cout)
    );

    always #5 clk = ~clk;

    // Behavioural 1-bit ALU slice (full adder, invert controls, Less input)
    logic m_a, m_b, m_sum;
    always_comb begin
        m_a        = slice_a ^ slice_ainvert;
        m_b        = slice_b ^ slice_binvert;
        m_sum      = m_a ^ m_b ^ slice_cin;
        slice_cout = (m_a & m_b) | (m_a & slice_cin) | (m_b & slice_cin);
        case (slice_op)
            2'b00:   slice_result = m_a & m_b;
            2'b01:   slice_result = m_a | m_b;
            2'b10:   slice_result = m_sum;
            default: slice_result = slice_less;
        endcase
    end

    typedef struct {
        logic [3:0]   ctl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         ov;
        logic         z;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         ov;
        logic         z;
        int           lat;
    } exp_t;

    vec_t tbl[12];
    exp_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] c);
`ifdef ALU_FAST_LOGIC_EN
        if (c[1] == 1'b0) return 1;
`endif
        return (c == 4'b0111) ? 33 : 32;
    endfunction

    // Drive one operation, optionally pulse in_valid mid-run and stall out_ready
    task automatic do_op(input vec_t v, input int pulse_at, input int hold, input string nm);
        exp_t e;
        exp_t got;
        int   cyc;
        @(negedge clk);
        op_a = v.a; op_b = v.b; alu_ctl = v.ctl; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.res = v.res; e.ov = v.ov; e.z = v.z; e.lat = exp_lat(v.ctl);
        sb.push_back(e);
        chk({nm, "_accept_ready"}, {63'd0, in_ready}, 64'd0);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (in_valid) begin
                in_valid = 1'b0;
                op_a = v.a; op_b = v.b; alu_ctl = v.ctl;
            end
            if (cyc == pulse_at) begin
                chk({nm, "_busy_ready"}, {63'd0, in_ready}, 64'd0);
                op_a = ~v.a; op_b = 32'h0000_0000; alu_ctl = 4'b0111; in_valid = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            chk({nm, "_timeout"}, 64'd0, 64'd1);
            void'(sb.pop_front());
        end else begin
            got = sb.pop_front();
            chk({nm, "_latency"}, 64'(cyc), 64'(got.lat));
            chk({nm, "_result"}, {32'd0, result}, {32'd0, got.res});
            chk({nm, "_zero"}, {63'd0, zero}, {63'd0, got.z});
            chk({nm, "_overflow"}, {63'd0, overflow}, {63'd0, got.ov});
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                chk({nm, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
                chk({nm, "_hold_ready"}, {63'd0, in_ready}, 64'd0);
                chk({nm, "_hold_result"}, {32'd0, result}, {32'd0, got.res});
                chk({nm, "_hold_flags"}, {62'd0, zero, overflow}, {62'd0, got.z, got.ov});
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk({nm, "_release_valid"}, {63'd0, out_valid}, 64'd0);
            chk({nm, "_release_ready"}, {63'd0, in_ready}, 64'd1);
        end
    endtask

    initial begin
        vec_t v;
        tbl[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0};
        tbl[1]  = '{4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b1};
        tbl[2]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
        tbl[3]  = '{4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
        tbl[4]  = '{4'b1100, 32'h0F0F_0000, 32'h00F0_000F, 32'hF000_FFF0, 1'b0, 1'b0};
        tbl[5]  = '{4'b0000, 32'hFFFF_0000, 32'h0FF0_0FF0, 32'h0FF0_0000, 1'b0, 1'b0};
        tbl[6]  = '{4'b0001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0};
        tbl[7]  = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1};
        tbl[8]  = '{4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0};
        tbl[9]  = '{4'b1101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FFF_0FFF, 1'b0, 1'b0};
        tbl[10] = '{4'b0111, 32'h0000_0003, 32'h0000_0005, 32'h0000_0001, 1'b0, 1'b0};
        tbl[11] = '{4'b0010, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0};

        // Reset state
        #12;
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_outputs", {29'd0, out_valid, zero, overflow, result},
            {29'd0, 3'b000, 32'h0000_0000});
        chk("reset_slice", {56'd0, slice_a, slice_b, slice_ainvert, slice_binvert,
            slice_op, slice_less, slice_cin}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_op(tbl[i], -1, 0, $sformatf("vec%0d", i));
        end

        // Ignored in_valid mid-run, then a stalled consumer
        v = '{4'b0010, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0};
        do_op(v, 5, 0, "midrun_pulse");
        v = '{4'b0110, 32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b0, 1'b0};
        do_op(v, -1, 3, "stall3");

        // Asynchronous reset at bit 10 of an ADD
        @(negedge clk);
        op_a = 32'h7FFF_FFFF; op_b = 32'h0000_0001; alu_ctl = 4'b0010; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
        end
        chk("abort_busy", {63'd0, in_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {29'd0, out_valid, zero, overflow, result},
            {29'd0, 3'b000, 32'h0000_0000});
        chk("abort_slice", {56'd0, slice_a, slice_b, slice_ainvert, slice_binvert,
            slice_op, slice_less, slice_cin}, 64'd0);
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready", {63'd0, in_ready}, 64'd1);
        chk("post_reset_valid", {63'd0, out_valid}, 64'd0);
        do_op(tbl[0], -1, 0, "post_reset_add");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Bit-serial ALU sequencer that sits directly upstream of, and around, the existing 1-bit ALU slice (full-adder-based, with A/B invert, Less input and 2-bit Operation select).
- Accepts a WIDTH-bit operation over a valid/ready handshake and walks the single slice across WIDTH bits, LSB first. It drives the slice's operands, invert controls, Operation, Less and carry-in, and consumes its Result and Cout.
- Assembles the WIDTH-bit result together with zero and overflow flags.
- The slice is external; the top level wires the slice_* ports to it.

Parameters:
- WIDTH, 32, operand/result width in bits (minimum 2).
- CNT_W, $clog2(WIDTH), bit-index counter width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  high only in IDLE.
- alu_ctl  in  4  {Ainvert, Binvert, Operation[1:0]}: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed.
- result  out  WIDTH  assembled result.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow, ADD/SUB/SLT only.
- slice_a, slice_b  out  1  current operand bits.
- slice_ainvert, slice_binvert  out  1  alu_ctl[3], alu_ctl[2] as latched.
- slice_op  out  2  Operation to slice.
- slice_less  out  1  Less to slice.
- slice_cin  out  1  carry into slice.
- slice_result  in  1  slice Result.
- slice_cout  in  1  slice Cout.

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0.
  - in_ready=1.
  - out_valid, result, zero, overflow = 0.
  - All slice_* outputs = 0.
  - Takes effect immediately mid-operation; the in-flight operation is discarded.
- States: IDLE, RUN, SLT_FIX, DONE.
- IDLE: in_valid & in_ready latches op_a, op_b, alu_ctl into a_q, b_q, ctl_q.
  - cnt=0, carry_q=alu_ctl[2], result register cleared; next state RUN.
- RUN (one bit per cycle):
  - slice_a=a_q[cnt], slice_b=b_q[cnt], slice_cin=carry_q, slice_less=0.
  - slice_op=ctl_q[1:0], except SLT, which is forced to 2'b10.
  - On each edge: result[cnt]<=slice_result, carry_q<=slice_cout, cnt++.
  - At cnt==WIDTH-1: capture msb_sum=slice_result and overflow=carry_q^slice_cout (ADD/SUB/SLT; otherwise 0).
  - Next state is SLT_FIX if ctl_q==0111, else DONE.
- SLT_FIX (one cycle): drive slice_a=a_q[0], slice_b=b_q[0], slice_op=2'b11, slice_less=msb_sum^overflow.
  - result <= {WIDTH-1 zeros, slice_result}; overflow is reported as computed.
  - Next state DONE.
- DONE: out_valid=1; result, zero and overflow are held stable until out_ready is sampled high, then IDLE.
  - zero is registered from the final result.
- Latency: out_valid rises WIDTH cycles after the accept edge (WIDTH+1 for SLT).
  - The earliest new accept is the cycle after the out_ready handshake; there is no overlap.
- in_valid while in_ready=0 is ignored, with no side effects; new operands must not disturb a_q/b_q.
- Other alu_ctl codes are legal: the slice is driven directly from the control bits (e.g. 1101 gives NAND). Only 0111 triggers SLT_FIX.
- Carry wraps out of the MSB and is discarded; no result truncation occurs.

Optional Feature:
- Macro ALU_FAST_LOGIC_EN.
- Defined: when ctl_q[1]==0 (AND/OR/NOR/NAND), RUN lasts one cycle.
  - Result is computed in parallel: (a_q^{WIDTH{ctl_q[3]}}) op (b_q^{WIDTH{ctl_q[2]}}).
  - Slice outputs are held 0; out_valid rises 1 cycle after accept.
- Undefined: all operations are serial as above.

Decomposition:
- Package alu_serial_pkg:
  - ALU_CTL_AND/OR/ADD/SUB/SLT/NOR localparams.
  - SLICE_OP_AND/OR/ADD/LESS 2-bit constants.
  - State enum (IDLE, RUN, SLT_FIX, DONE).
- No sub-module: the counter and result register are inline; the slice stays external.

Test Plan (WIDTH=32, slice model wired):
- ADD 0x7FFFFFFF+0x00000001 -> result 0x80000000, overflow=1, zero=0; out_valid exactly 32 cycles after accept.
- SUB 0x00000005-0x00000005 -> result 0, zero=1, overflow=0.
- SLT 0xFFFFFFFF vs 0x00000001 -> result 1; SLT 0x7FFFFFFF vs 0x80000000 -> result 0, overflow=1; each at 33 cycles.
- NOR 0x0F0F0000,0x00F0000F -> result 0xF000FFF0.
- Control and reset:
  - in_valid pulsed with new operands mid-RUN -> ignored, result unchanged.
  - out_ready held low 3 cycles -> outputs stable, in_ready=0.
  - rst_n low at bit 10 of an ADD -> all outputs 0 immediately; in_ready=1 after release.
- With ALU_FAST_LOGIC_EN: AND 0xFFFF0000,0x0FF00FF0 -> 0x0FF00000, out_valid 1 cycle after accept; ADD latency remains 32.
